// File: rtl/btn_pkg.sv
// Shared types and helpers for the multi-channel pushbutton processor.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      HELD     = 2'd3
   } btn_state_e;

   // Bits needed to hold the largest of the three tick counts.
   function automatic int cnt_width(input int a, input int b, input int c);
      longint m;
      int     w;
      m = longint'(a);
      if (longint'(b) > m) m = longint'(b);
      if (longint'(c) > m) m = longint'(c);
      w = 1;
      while ((longint'(1) << w) < (m + 1)) w++;
      return w;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: two-flop synchroniser, debounce and
// short/long/repeat classification FSM sharing a single counter.
module button_channel
   import btn_pkg::*;
#(
   parameter int ACTIVE_LOW     = 0,
   parameter int DEBOUNCE_TICKS = 20000,
   parameter int LONG_TICKS     = 2000000,
   parameter int REPEAT_EN      = 0,
   parameter int REPEAT_TICKS   = 250000,
   parameter int CNT_W          = cnt_width(DEBOUNCE_TICKS, LONG_TICKS, REPEAT_TICKS)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic short_o,
   output logic long_o,
   output logic repeat_o,
   output logic pressed_o
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

   logic             sync1_q, s_q;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;

   // Polarity is folded in ahead of the synchroniser so reset loads "released".
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         s_q      <= 1'b0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
      end else begin
         sync1_q  <= btn_i ^ (ACTIVE_LOW != 0);
         s_q      <= sync1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         long_q   <= long_d;
         repeat_q <= repeat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (s_q) state_d = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!s_q) begin
               short_d = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               long_d  = 1'b1;
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (REPEAT_EN != 0) begin
               if (cnt_q == REP_LAST) begin
                  repeat_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign short_o   = short_q;
   assign long_o    = long_q;
   assign repeat_o  = repeat_q;
   assign pressed_o = (state_q == PRESSED) || (state_q == HELD);

endmodule

// File: rtl/multi_button_processor.sv
// N independent button channels plus a one-cycle-delayed combined event flag.
module multi_button_processor
   import btn_pkg::*;
#(
   parameter int N_BUTTONS      = 2,
   parameter int ACTIVE_LOW     = 0,
   parameter int DEBOUNCE_TICKS = 20000,
   parameter int LONG_TICKS     = 2000000,
   parameter int REPEAT_EN      = 0,
   parameter int REPEAT_TICKS   = 250000
) (
   input  logic                 clk_1mhz,
   input  logic                 rst_n,
   input  logic [N_BUTTONS-1:0] btn_i,
   output logic [N_BUTTONS-1:0] short_o,
   output logic [N_BUTTONS-1:0] long_o,
   output logic [N_BUTTONS-1:0] repeat_o,
   output logic [N_BUTTONS-1:0] pressed_o,
   output logic                 event_o
);

   localparam int CNT_W = cnt_width(DEBOUNCE_TICKS, LONG_TICKS, REPEAT_TICKS);

   logic event_q, event_d;

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
      button_channel #(
         .ACTIVE_LOW    (ACTIVE_LOW),
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
         .LONG_TICKS    (LONG_TICKS),
         .REPEAT_EN     (REPEAT_EN),
         .REPEAT_TICKS  (REPEAT_TICKS),
         .CNT_W         (CNT_W)
      ) u_chan (
         .clk_i    (clk_1mhz),
         .rst_ni   (rst_n),
         .btn_i    (btn_i[g]),
         .short_o  (short_o[g]),
         .long_o   (long_o[g]),
         .repeat_o (repeat_o[g]),
         .pressed_o(pressed_o[g])
      );
   end

   assign event_d = |(short_o | long_o | repeat_o);

   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) event_q <= 1'b0;
      else        event_q <= event_d;
   end

   assign event_o = event_q;

endmodule

// File: doc/multi_button_processor.md
Name: multi_button_processor

Overview:
- Parameterised, multi-channel successor to the single-button short/long-press processor.
- Each of N_BUTTONS raw pushbutton inputs is synchronised and debounced, then classified.
  - Short press: one-cycle pulse on release.
  - Long press: one-cycle pulse once the hold threshold is reached.
  - Optional auto-repeat pulses while the button stays held.
- Sits between the board pushbutton pins and the scoreboard counter/display logic. All outputs are registered, in the clk_1mhz domain.

Parameters:
- N_BUTTONS, 2, number of independent button channels (>=1).
- ACTIVE_LOW, 0, 1 = raw input pressed when 0; polarity applied before the synchroniser.
- DEBOUNCE_TICKS, 20000, consecutive pressed cycles needed to accept a press (>=1).
- LONG_TICKS, 2000000, cycles in PRESSED before a long press fires (>=1).
- REPEAT_EN, 0, 1 = emit repeat_o pulses while held after a long press.
- REPEAT_TICKS, 250000, cycles between repeat pulses (>=1).
- CNT_W, derived, $clog2(max(DEBOUNCE_TICKS,LONG_TICKS,REPEAT_TICKS)+1).

Ports:
- clk_1mhz  in  1  system clock, 1 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn_i  in  N_BUTTONS  raw asynchronous pushbutton levels.
- short_o  out  N_BUTTONS  one-cycle pulse per channel on short press release.
- long_o  out  N_BUTTONS  one-cycle pulse per channel when long threshold is reached.
- repeat_o  out  N_BUTTONS  one-cycle auto-repeat pulses; tied 0 when REPEAT_EN=0.
- pressed_o  out  N_BUTTONS  level, high while the channel is in PRESSED or HELD.
- event_o  out  1  registered OR of all short/long/repeat pulses of the previous cycle.

Behaviour:
- Reset (rst_n=0, async):
  - All outputs 0; every channel in IDLE; counters 0.
  - Synchroniser flops load the inactive level, so no spurious press after release of reset.
- Synchroniser: p = btn_i XOR ACTIVE_LOW, then two flops. s is the second-flop output. Only s is used by the FSM.
- Per-channel FSM, evaluated each rising edge:
  - IDLE: cnt=0. If s=1, go to DEBOUNCE with cnt=0.
  - DEBOUNCE:
    - s=0: go to IDLE, no output.
    - s=1 and cnt==DEBOUNCE_TICKS-1: go to PRESSED, cnt=0.
    - Otherwise cnt+1.
  - PRESSED:
    - s=0: short_o=1 for one cycle, go to IDLE.
    - s=1 and cnt==LONG_TICKS-1: long_o=1 for one cycle, go to HELD, cnt=0.
    - Otherwise cnt+1.
  - HELD:
    - s=0: go to IDLE, no pulse.
    - REPEAT_EN=1 and cnt==REPEAT_TICKS-1: repeat_o=1 for one cycle, cnt=0.
    - Otherwise, with REPEAT_EN=1, cnt+1. With REPEAT_EN=0, cnt holds at 0.
- Latency (edge 1 = first edge sampling the raw press):
  - long_o is high after edge 3+DEBOUNCE_TICKS+LONG_TICKS.
  - The n-th repeat_o follows n*REPEAT_TICKS edges later.
  - short_o is high after the 3rd edge following raw release.
- Exclusivity:
  - short_o, long_o and repeat_o are mutually exclusive per channel.
  - At most one press classification (short or long) per physical press.
- Channels are fully independent. Simultaneous events on several channels all appear in the same cycle, and event_o asserts once, one cycle later.
- The counter never wraps: every compare is an exact equality reached from 0, and cnt is cleared on each transition.
- Glitch shorter than DEBOUNCE_TICKS: returns to IDLE silently.
- Release during the debounce window: no output.
- Reset mid-press: channel restarts in IDLE with no pulse. A button still held after reset re-enters DEBOUNCE and is classified normally.
- Unused FSM encodings recover to IDLE on the next edge.

Decomposition:
- Package btn_pkg:
  - State enum IDLE/DEBOUNCE/PRESSED/HELD (2-bit).
  - Function clog2-of-max for CNT_W.
- Sub-module button_channel:
  - One synchroniser, FSM and counter per instance.
  - Generate-instantiated N_BUTTONS times.
  - The top holds only the generate loop and the event_o register.

Test Plan (DEBOUNCE_TICKS=4, LONG_TICKS=20, REPEAT_TICKS=5, N_BUTTONS=2):
- Reset mid-press: hold btn_i[0]=1, pulse rst_n low 3 cycles mid-PRESSED, keep held 12 cycles after release of reset, then release -> no pulse during or after reset; exactly one short_o[0].
- Short press: btn_i[0]=1 for 12 cycles, then 0 -> pressed_o[0] high from edge 7; exactly one short_o[0] pulse 3 edges after release; long_o/repeat_o stay 0; event_o pulses one cycle later.
- Long press with repeat: REPEAT_EN=1, btn_i[1]=1 held 40 cycles -> long_o[1] high after edge 27; repeat_o[1] after edges 32 and 37; no short_o[1] on release.
- Glitch rejection: btn_i[0]=1 for 3 cycles, then 0 -> no outputs, pressed_o[0] stays 0.
- Simultaneous and polarity: ACTIVE_LOW=1, both btn_i from 11 to 00 for 12 cycles, then 11 -> short_o=11 in the same cycle; event_o single pulse next cycle.
